// File: rtl/race_time_display_if.sv
// race_time_display_if
//   Bundles the data/status signals between the game top and the race time
//   display block. Clock and reset stay as plain ports on the modules.
//
//   master : game-top side. It drives secondsIn, raceDone and showBest, and
//            observes the segment outputs and the best-time status.
//   slave  : display block side, the mirror image of master.
//
//   secondsIn   8  elapsed race seconds (0..255)
//   raceDone    1  level, high once the race has finished
//   showBest    1  level, 1 selects the best time as the display source
//   HEX0..HEX2  7  ones/tens/hundreds segments {g,f,e,d,c,b,a}
//   busy        1  binary-to-BCD conversion in progress
//   bestSeconds 8  best (lowest) finish time
//   bestValid   1  at least one finish time has been recorded
interface race_time_display_if;
    logic [7:0] secondsIn;
    logic       raceDone;
    logic       showBest;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic       busy;
    logic [7:0] bestSeconds;
    logic       bestValid;

    modport master (
        output secondsIn, raceDone, showBest,
        input  HEX0, HEX1, HEX2, busy, bestSeconds, bestValid
    );

    modport slave (
        input  secondsIn, raceDone, showBest,
        output HEX0, HEX1, HEX2, busy, bestSeconds, bestValid
    );
endinterface

// File: rtl/race_time_display.sv
// race_time_display
//   Shows an 8-bit seconds count on three 7-segment digits (HEX2..HEX0).
//   The binary value is converted to BCD with a sequential double-dabble
//   (one shift per clock), then decoded to segments. It also keeps the best
//   (lowest) finish time, committed on each rising edge of raceDone.
//   showBest selects whether the best time or the live time is displayed.
//
//   Parameters
//     BLANK_LEADING  1: blank leading zero hundreds/tens digits
//     SEG_ACTIVE_LOW 1: segment bit 0 = lit; 0: all segment bits inverted
//
//   Ports
//     Clock   system clock
//     Resetn  synchronous, active-low reset
//     bus     race_time_display_if.slave (secondsIn, raceDone, showBest in;
//             HEX0..HEX2, busy, bestSeconds, bestValid out)
module race_time_display #(
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               Clock,
    input  logic               Resetn,
    race_time_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateType;

    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [6:0] SEG_DASH = SEG_ACTIVE_LOW ? 7'b0111111 : 7'b1000000;

    stateType   state;
    stateType   nextState;

    logic [19:0] sr;          // {hundreds, tens, ones, binary}
    logic [7:0]  lastVal;
    logic [2:0]  cnt;
    logic        forceConv;
    logic [6:0]  hex0Reg;
    logic [6:0]  hex1Reg;
    logic [6:0]  hex2Reg;
    logic        raceDonePrev;
    logic [7:0]  bestReg;
    logic        bestValidReg;

    logic [7:0]  src;
    logic        noBest;
    logic        startConv;
    logic        shiftEn;
    logic        loadHex;
    logic        showDash;

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? pattern : ~pattern;
    endfunction

    // One double-dabble step: correct every BCD nibble that would overflow
    // past 9 when doubled, then shift the whole register left by one.
    function automatic logic [19:0] dabbleStep(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    assign src    = bus.showBest ? bestReg : bus.secondsIn;
    assign noBest = bus.showBest && !bestValidReg;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        startConv = 1'b0;
        shiftEn   = 1'b0;
        loadHex   = 1'b0;
        showDash  = 1'b0;
        case (state)
            IDLE: begin
                // Nothing to show yet: dashes, and forget the last converted
                // value so leaving this mode always reconverts.
                if (noBest) begin
                    showDash = 1'b1;
                end else if (forceConv || (src != lastVal)) begin
                    startConv = 1'b1;
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                shiftEn = 1'b1;
                if (cnt == 3'd7) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                loadHex   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Conversion data path: no reset needed, every conversion reloads it.
    always_ff @(posedge Clock) begin
        if (startConv) begin
            sr      <= {12'b0, src};
            lastVal <= src;
        end else if (shiftEn) begin
            sr <= dabbleStep(sr);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt       <= 3'd0;
            forceConv <= 1'b1;
            hex0Reg   <= SEG_OFF;
            hex1Reg   <= SEG_OFF;
            hex2Reg   <= SEG_OFF;
        end else begin
            if (showDash) begin
                forceConv <= 1'b1;
                hex0Reg   <= SEG_DASH;
                hex1Reg   <= SEG_DASH;
                hex2Reg   <= SEG_DASH;
            end
            if (startConv) begin
                cnt       <= 3'd0;
                forceConv <= 1'b0;
            end
            if (shiftEn) begin
                cnt <= cnt + 3'd1;
            end
            if (loadHex) begin
                hex0Reg <= segDecode(sr[11:8]);
                hex1Reg <= (BLANK_LEADING && (sr[19:16] == 4'd0) && (sr[15:12] == 4'd0))
                           ? SEG_OFF : segDecode(sr[15:12]);
                hex2Reg <= (BLANK_LEADING && (sr[19:16] == 4'd0))
                           ? SEG_OFF : segDecode(sr[19:16]);
            end
        end
    end

    // Best time: committed on the registered rising edge of raceDone; a tie
    // keeps the earlier record.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            raceDonePrev <= 1'b0;
            bestReg      <= 8'd0;
            bestValidReg <= 1'b0;
        end else begin
            raceDonePrev <= bus.raceDone;
            if (bus.raceDone && !raceDonePrev &&
                (!bestValidReg || (bus.secondsIn < bestReg))) begin
                bestReg      <= bus.secondsIn;
                bestValidReg <= 1'b1;
            end
        end
    end

    assign bus.HEX0        = hex0Reg;
    assign bus.HEX1        = hex1Reg;
    assign bus.HEX2        = hex2Reg;
    assign bus.busy        = (state != IDLE);
    assign bus.bestSeconds = bestReg;
    assign bus.bestValid   = bestValidReg;

endmodule

// File: tb/tb_race_time_display.sv
// tb_race_time_display
//   Randomized and directed stimulus for race_time_display, checked against a
//   decimal/min() reference model of the display and best-time rules.
module tb_race_time_display;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clock = ~Clock;

    race_time_display_if bus();

    race_time_display #(
        .BLANK_LEADING (1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0]  SEG_OFF  = 7'b1111111;
    localparam logic [6:0]  SEG_DASH = 7'b0111111;
    localparam logic [20:0] ALL_OFF  = {SEG_OFF, SEG_OFF, SEG_OFF};
    localparam logic [20:0] ALL_DASH = {SEG_DASH, SEG_DASH, SEG_DASH};

    int passCount  = 0;
    int totalCount = 0;
    int shownV;
    logic [20:0] shownExp;
    int bestExp;
    bit validExp;

    logic [20:0] disp;
    assign disp = {bus.HEX2, bus.HEX1, bus.HEX0};

    // Reference display for a value: plain decimal digits with leading-zero blanking.
    function automatic logic [20:0] expHex(input int v);
        int h, t, o;
        logic [6:0] s2, s1, s0;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        s0 = SEG_DIGIT[o];
        s1 = (h == 0 && t == 0) ? SEG_OFF : SEG_DIGIT[t];
        s2 = (h == 0) ? SEG_OFF : SEG_DIGIT[h];
        return {s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        bus.secondsIn = 8'd0;
        bus.raceDone  = 1'b0;
        bus.showBest  = 1'b0;
        tick();
        tick();
        totalCount++;
        if (disp !== ALL_OFF) $display("FAIL reset_hex: got %b required %b", disp, ALL_OFF);
        else passCount++;
        totalCount++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy);
        else passCount++;
        totalCount++;
        if (bus.bestSeconds !== 8'd0) $display("FAIL reset_best: got %0d required 0", bus.bestSeconds);
        else passCount++;
        totalCount++;
        if (bus.bestValid !== 1'b0) $display("FAIL reset_bestValid: got %b required 0", bus.bestValid);
        else passCount++;
        validExp = 1'b0;
        bestExp  = 0;
    endtask

    task automatic test_first_conversion();
        int busyCount;
        busyCount = 0;
        Resetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.busy === 1'b1) busyCount++;
        end
        totalCount++;
        if (disp !== ALL_OFF) $display("FAIL first_hold: got %b required %b", disp, ALL_OFF);
        else passCount++;
        tick();
        if (bus.busy === 1'b1) busyCount++;
        totalCount++;
        if (busyCount !== 9) $display("FAIL first_busy_cycles: got %0d required 9", busyCount);
        else passCount++;
        shownV   = 0;
        shownExp = expHex(0);
        totalCount++;
        if (disp !== shownExp) $display("FAIL first_zero: got %b required %b", disp, shownExp);
        else passCount++;
    endtask

    // Fixed corner values then random ones; each is checked for exact
    // 10-edge latency (old display still up after 9 edges).
    task automatic test_conversion();
        int v;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) v = 255;
            else if (i == 1) v = 7;
            else begin
                do v = int'($urandom_range(13, 255)); while (v == shownV);
            end
            bus.secondsIn = 8'(v);
            repeat (9) tick();
            totalCount++;
            if (disp !== shownExp)
                $display("FAIL conv_hold_%0d: got %b required %b", v, disp, shownExp);
            else passCount++;
            tick();
            shownV   = v;
            shownExp = expHex(v);
            totalCount++;
            if (disp !== shownExp)
                $display("FAIL conv_value_%0d: got %b required %b", v, disp, shownExp);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        bus.secondsIn = 8'd12;
        tick();                  // E0 samples 12
        tick();
        tick();
        bus.secondsIn = 8'd34;   // seen at E3, ignored by the running conversion
        repeat (7) tick();
        totalCount++;
        if (disp !== expHex(12)) $display("FAIL b2b_first_12: got %b required %b", disp, expHex(12));
        else passCount++;
        repeat (9) tick();
        totalCount++;
        if (disp !== expHex(12)) $display("FAIL b2b_hold_12: got %b required %b", disp, expHex(12));
        else passCount++;
        tick();
        shownV   = 34;
        shownExp = expHex(34);
        totalCount++;
        if (disp !== shownExp) $display("FAIL b2b_final_34: got %b required %b", disp, shownExp);
        else passCount++;
    endtask

    task automatic test_best();
        int v;
        int fixedTimes [4] = '{40, 35, 35, 50};
        for (int i = 0; i < 12; i++) begin
            v = (i < 4) ? fixedTimes[i] : int'($urandom_range(0, 255));
            bus.secondsIn = 8'(v);
            bus.raceDone  = 1'b1;
            tick();
            if (!validExp || v < bestExp) begin
                bestExp  = v;
                validExp = 1'b1;
            end
            totalCount++;
            if (bus.bestSeconds !== 8'(bestExp) || bus.bestValid !== validExp)
                $display("FAIL best_pulse_%0d: got %0d/%b required %0d/%b",
                         i, bus.bestSeconds, bus.bestValid, bestExp, validExp);
            else passCount++;
            bus.raceDone = 1'b0;
            tick();
        end
        // A level that stays high must not commit a later, lower time.
        bus.secondsIn = 8'(bestExp);
        bus.raceDone  = 1'b1;
        tick();
        bus.secondsIn = 8'd0;
        repeat (4) tick();
        totalCount++;
        if (bus.bestSeconds !== 8'(bestExp))
            $display("FAIL best_level_no_retrigger: got %0d required %0d", bus.bestSeconds, bestExp);
        else passCount++;
        bus.raceDone  = 1'b0;
        bus.secondsIn = 8'd201;
        repeat (25) tick();
        shownV   = 201;
        shownExp = expHex(201);
        totalCount++;
        if (disp !== shownExp) $display("FAIL best_display_settles: got %b required %b", disp, shownExp);
        else passCount++;
    endtask

    task automatic test_show_best();
        Resetn        = 1'b0;
        bus.showBest  = 1'b1;
        bus.raceDone  = 1'b0;
        bus.secondsIn = 8'd77;
        tick();
        tick();
        Resetn = 1'b1;
        validExp = 1'b0;
        tick();
        tick();
        totalCount++;
        if (disp !== ALL_DASH) $display("FAIL dash_no_best: got %b required %b", disp, ALL_DASH);
        else passCount++;
        repeat (12) tick();
        totalCount++;
        if ({bus.busy, disp} !== {1'b0, ALL_DASH})
            $display("FAIL dash_idle: got %b required %b", {bus.busy, disp}, {1'b0, ALL_DASH});
        else passCount++;
        bus.showBest = 1'b0;
        repeat (10) tick();
        totalCount++;
        if (disp !== expHex(77)) $display("FAIL dash_clear_77: got %b required %b", disp, expHex(77));
        else passCount++;
        bus.showBest = 1'b1;
        tick();
        tick();
        totalCount++;
        if (disp !== ALL_DASH) $display("FAIL dash_again: got %b required %b", disp, ALL_DASH);
        else passCount++;
        // Same live value as before the dashes: must still reconvert.
        bus.showBest = 1'b0;
        repeat (9) tick();
        totalCount++;
        if (disp !== ALL_DASH) $display("FAIL reconv_hold: got %b required %b", disp, ALL_DASH);
        else passCount++;
        tick();
        totalCount++;
        if (disp !== expHex(77)) $display("FAIL reconv_same_77: got %b required %b", disp, expHex(77));
        else passCount++;
        bus.showBest = 1'b1;
        tick();
        bus.secondsIn = 8'd35;
        bus.raceDone  = 1'b1;
        tick();
        bus.raceDone = 1'b0;
        bestExp  = 35;
        validExp = 1'b1;
        totalCount++;
        if (bus.bestSeconds !== 8'd35 || bus.bestValid !== 1'b1)
            $display("FAIL best_first_35: got %0d/%b required 35/1", bus.bestSeconds, bus.bestValid);
        else passCount++;
        repeat (9) tick();
        totalCount++;
        if (disp !== ALL_DASH) $display("FAIL best35_hold: got %b required %b", disp, ALL_DASH);
        else passCount++;
        tick();
        totalCount++;
        if (disp !== expHex(35)) $display("FAIL best35_shown: got %b required %b", disp, expHex(35));
        else passCount++;
        bus.secondsIn = 8'd20;
        bus.raceDone  = 1'b1;
        tick();
        bus.raceDone = 1'b0;
        bestExp = 20;
        repeat (10) tick();
        totalCount++;
        if (disp !== expHex(20)) $display("FAIL best_update_20: got %b required %b", disp, expHex(20));
        else passCount++;
        bus.showBest  = 1'b0;
        bus.secondsIn = 8'd150;
        repeat (10) tick();
        shownV   = 150;
        shownExp = expHex(150);
        totalCount++;
        if (disp !== shownExp) $display("FAIL live_150: got %b required %b", disp, shownExp);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        bus.secondsIn = 8'd99;
        repeat (4) tick();       // E0..E3
        Resetn = 1'b0;
        tick();                  // E4 is a reset edge
        totalCount++;
        if (disp !== ALL_OFF) $display("FAIL midreset_hex: got %b required %b", disp, ALL_OFF);
        else passCount++;
        totalCount++;
        if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b required 0", bus.busy);
        else passCount++;
        totalCount++;
        if (bus.bestSeconds !== 8'd0 || bus.bestValid !== 1'b0)
            $display("FAIL midreset_best: got %0d/%b required 0/0", bus.bestSeconds, bus.bestValid);
        else passCount++;
        Resetn = 1'b1;
        repeat (9) tick();
        totalCount++;
        if (disp !== ALL_OFF) $display("FAIL midreset_hold: got %b required %b", disp, ALL_OFF);
        else passCount++;
        tick();
        totalCount++;
        if (disp !== expHex(99)) $display("FAIL midreset_99: got %b required %b", disp, expHex(99));
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_first_conversion();
        test_conversion();
        test_back_to_back();
        test_best();
        test_show_best();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
